// File: rtl/instruction_fetcher.sv
// Instruction fetch front end: owns the PC, looks up one word per cycle in the
// instruction cache, refills the cache from memory on a miss and hands hits to
// the instruction queue. A redirect reloads the PC at any point.
//
// state  | meaning
// FETCH  | look up pc; hit issues an instruction, miss starts a memory read
// MISS   | memory read for miss_addr outstanding
// REFILL | fetched word being written into the cache at miss_addr
// ABORT  | redirected during a miss; read still completes and refills, no issue
module instruction_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic [31:0] ic_addr,
  input  logic        ic_hit,
  input  logic [31:0] ic_result,
  output logic        ic_wr,
  output logic [31:0] ic_value,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  input  logic        iq_full,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        flush,
  input  logic [31:0] flush_pc
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_MISS   = 2'd1,
    S_REFILL = 2'd2,
    S_ABORT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] miss_addr;
  logic [31:0] miss_addr_nxt;
  logic        ic_wr_nxt;
  logic [31:0] ic_value_nxt;
  logic        mem_req_nxt;
  logic [31:0] mem_addr_nxt;
  logic        inst_valid_nxt;
  logic [31:0] inst_nxt;
  logic [31:0] inst_pc_nxt;

  // Outside FETCH the cache port is pointed at the line being refilled.
  assign ic_addr = (state == S_FETCH) ? pc : miss_addr;

  // State register: reset wins, rdy_in low freezes.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= S_FETCH;
    end else if (rdy_in) begin
      state <= state_nxt;
    end
  end

  // Next state: a redirect never cancels an outstanding memory read.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (!flush && !iq_full && !ic_hit) begin
          state_nxt = S_MISS;
        end
      end
      S_MISS: begin
        if (mem_done) begin
          state_nxt = S_REFILL;
        end else if (flush) begin
          state_nxt = S_ABORT;
        end
      end
      S_REFILL: begin
        state_nxt = S_FETCH;
      end
      S_ABORT: begin
        if (mem_done) begin
          state_nxt = S_REFILL;
        end
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // Datapath and registered outputs: strobes default low, everything else holds.
  always_comb begin
    pc_nxt         = pc;
    miss_addr_nxt  = miss_addr;
    ic_wr_nxt      = 1'b0;
    ic_value_nxt   = ic_value;
    mem_req_nxt    = mem_req;
    mem_addr_nxt   = mem_addr;
    inst_valid_nxt = 1'b0;
    inst_nxt       = inst;
    inst_pc_nxt    = inst_pc;

    if (flush) begin
      pc_nxt = flush_pc;
    end

    case (state)
      S_FETCH: begin
        // A redirect in FETCH suppresses both the hit and the miss request.
        if (!flush && !iq_full) begin
          if (ic_hit) begin
            inst_valid_nxt = 1'b1;
            inst_nxt       = ic_result;
            inst_pc_nxt    = pc;
            pc_nxt         = pc + 32'd4;
          end else begin
            miss_addr_nxt = pc;
            mem_req_nxt   = 1'b1;
            mem_addr_nxt  = pc;
          end
        end
      end
      S_MISS, S_ABORT: begin
        if (mem_done) begin
          mem_req_nxt  = 1'b0;
          ic_wr_nxt    = 1'b1;
          ic_value_nxt = mem_data;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers: reset wins, rdy_in low freezes.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pc         <= RESET_PC;
      miss_addr  <= 32'h0;
      ic_wr      <= 1'b0;
      ic_value   <= 32'h0;
      mem_req    <= 1'b0;
      mem_addr   <= 32'h0;
      inst_valid <= 1'b0;
      inst       <= 32'h0;
      inst_pc    <= 32'h0;
    end else if (rdy_in) begin
      pc         <= pc_nxt;
      miss_addr  <= miss_addr_nxt;
      ic_wr      <= ic_wr_nxt;
      ic_value   <= ic_value_nxt;
      mem_req    <= mem_req_nxt;
      mem_addr   <= mem_addr_nxt;
      inst_valid <= inst_valid_nxt;
      inst       <= inst_nxt;
      inst_pc    <= inst_pc_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Bench for instruction_fetcher: directed scenarios plus a randomized run
// checked against an instruction-stream model (sequential PCs, redirects).
module tb_instruction_fetcher;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] ic_addr;
  logic        ic_hit;
  logic [31:0] ic_result;
  logic        ic_wr;
  logic [31:0] ic_value;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic        iq_full;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        flush;
  logic [31:0] flush_pc;

  int vectors = 0;
  int miscompares = 0;

  // Direct-mapped cache model with full-address tags.
  logic        c_val  [256];
  logic [31:0] c_tag  [256];
  logic [31:0] c_data [256];
  logic [7:0]  c_idx;

  // Memory controller model state.
  bit          mem_auto = 1'b0;
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_req_addr = 32'h0;

  instruction_fetcher #(.RESET_PC(RESET_PC)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .ic_addr   (ic_addr),
    .ic_hit    (ic_hit),
    .ic_result (ic_result),
    .ic_wr     (ic_wr),
    .ic_value  (ic_value),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_done  (mem_done),
    .mem_data  (mem_data),
    .iq_full   (iq_full),
    .inst_valid(inst_valid),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .flush     (flush),
    .flush_pc  (flush_pc)
  );

  initial forever #5 clk_in = ~clk_in;

  always_comb begin
    c_idx     = ic_addr[9:2];
    ic_hit    = c_val[c_idx] && (c_tag[c_idx] == ic_addr);
    ic_result = c_data[c_idx];
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic cache_clear();
    for (int i = 0; i < 256; i++) c_val[i] = 1'b0;
  endtask

  task automatic cache_put(input logic [31:0] a, input logic [31:0] v);
    c_val[a[9:2]]  = 1'b1;
    c_tag[a[9:2]]  = a;
    c_data[a[9:2]] = v;
  endtask

  // One clock: memory model decides mem_done, cache captures a pending write
  // at the edge, outputs are then sampled at the following negedge.
  task automatic tick();
    logic        wr_en;
    logic [31:0] wa;
    logic [31:0] wv;
    if (mem_auto) begin
      mem_done = 1'b0;
      if (rdy_in) begin
        if (!mem_busy && mem_req === 1'b1) begin
          mem_busy     = 1'b1;
          mem_cnt      = $urandom_range(0, 4);
          mem_req_addr = mem_addr;
        end
        if (mem_busy) begin
          if (mem_cnt == 0) begin
            mem_done = 1'b1;
            mem_data = word_of(mem_req_addr);
            mem_busy = 1'b0;
          end else begin
            mem_cnt--;
          end
        end
      end
    end
    wr_en = (ic_wr === 1'b1);
    wa    = ic_addr;
    wv    = ic_value;
    @(posedge clk_in);
    if (wr_en) cache_put(wa, wv);
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst_in   = 1'b0;
    rdy_in   = 1'b1;
    flush    = 1'b0;
    flush_pc = 32'h0;
    iq_full  = 1'b0;
    mem_done = 1'b0;
    mem_data = 32'h0;
    mem_auto = 1'b0;
    mem_busy = 1'b0;
    tick();
    rst_in = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] got [8];
    logic [31:0] want[8];
    string       nm  [8];
    cache_clear();
    rst_in = 1'b0; rdy_in = 1'b0; flush = 1'b1; flush_pc = 32'h40;
    iq_full = 1'b0; mem_done = 1'b1; mem_data = 32'hDEAD_BEEF;
    tick();
    tick();
    got[0] = 32'(ic_wr);      want[0] = 32'h0;     nm[0] = "rst_ic_wr";
    got[1] = ic_value;        want[1] = 32'h0;     nm[1] = "rst_ic_value";
    got[2] = 32'(mem_req);    want[2] = 32'h0;     nm[2] = "rst_mem_req";
    got[3] = mem_addr;        want[3] = 32'h0;     nm[3] = "rst_mem_addr";
    got[4] = 32'(inst_valid); want[4] = 32'h0;     nm[4] = "rst_inst_valid";
    got[5] = inst;            want[5] = 32'h0;     nm[5] = "rst_inst";
    got[6] = inst_pc;         want[6] = 32'h0;     nm[6] = "rst_inst_pc";
    got[7] = ic_addr;         want[7] = RESET_PC;  nm[7] = "rst_ic_addr";
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (got[i] !== want[i]) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", nm[i], got[i], want[i]);
      end
    end
    flush = 1'b0; mem_done = 1'b0; rdy_in = 1'b1; rst_in = 1'b1;
  endtask

  task automatic test_hits();
    cache_clear();
    for (int i = 0; i < 3; i++) cache_put(32'(i * 4), word_of(32'(i * 4)));
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(i * 4) || inst !== word_of(32'(i * 4))) begin
        miscompares++;
        $display("FAIL hits_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 i, inst_valid, inst_pc, inst, 32'(i * 4), word_of(32'(i * 4)));
      end
    end
    tick();
    vectors++;
    if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'hC) begin
      miscompares++;
      $display("FAIL hits_then_miss: got v=%b req=%b addr=%h want v=0 req=1 addr=0000000c",
               inst_valid, mem_req, mem_addr);
    end
  endtask

  task automatic test_cold_miss();
    cache_clear();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0 || ic_wr !== 1'b0 || inst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL cold_wait_%0d: got req=%b addr=%h wr=%b v=%b want req=1 addr=0 wr=0 v=0",
                 k, mem_req, mem_addr, ic_wr, inst_valid);
      end
    end
    mem_done = 1'b1; mem_data = 32'h0050_0093;
    tick();
    mem_done = 1'b0;
    vectors++;
    if (mem_req !== 1'b0 || ic_wr !== 1'b1 || ic_value !== 32'h0050_0093 || ic_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL cold_refill: got req=%b wr=%b val=%h ic_addr=%h want req=0 wr=1 val=00500093 ic_addr=0",
               mem_req, ic_wr, ic_value, ic_addr);
    end
    tick();
    vectors++;
    if (ic_wr !== 1'b0 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL cold_wr_pulse: got wr=%b v=%b want wr=0 v=0", ic_wr, inst_valid);
    end
    tick();
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h0050_0093) begin
      miscompares++;
      $display("FAIL cold_issue: got v=%b pc=%h inst=%h want v=1 pc=0 inst=00500093",
               inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_iq_full();
    cache_clear();
    cache_put(32'h0, word_of(32'h0));
    do_reset();
    iq_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (inst_valid !== 1'b0 || ic_addr !== 32'h0 || mem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL iqfull_hold_%0d: got v=%b ic_addr=%h req=%b want v=0 ic_addr=0 req=0",
                 k, inst_valid, ic_addr, mem_req);
      end
    end
    iq_full = 1'b0;
    tick();
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== word_of(32'h0)) begin
      miscompares++;
      $display("FAIL iqfull_release: got v=%b pc=%h inst=%h want v=1 pc=0 inst=%h",
               inst_valid, inst_pc, inst, word_of(32'h0));
    end
    iq_full = 1'b1;
    tick();
    vectors++;
    if (inst_valid !== 1'b0 || ic_addr !== 32'h4 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL iqfull_blocks_miss: got v=%b ic_addr=%h req=%b want v=0 ic_addr=4 req=0",
               inst_valid, ic_addr, mem_req);
    end
    iq_full = 1'b0;
  endtask

  task automatic test_flush_miss();
    bit seen_inst;
    cache_clear();
    cache_put(32'h100, word_of(32'h100));
    do_reset();
    flush = 1'b1; flush_pc = 32'h20;
    tick();
    flush = 1'b0;
    vectors++;
    if (mem_req !== 1'b0 || ic_addr !== 32'h20) begin
      miscompares++;
      $display("FAIL fmiss_redirect: got req=%b ic_addr=%h want req=0 ic_addr=20", mem_req, ic_addr);
    end
    tick();
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
      miscompares++;
      $display("FAIL fmiss_request: got req=%b addr=%h want req=1 addr=20", mem_req, mem_addr);
    end
    flush = 1'b1; flush_pc = 32'h100;
    tick();
    flush = 1'b0;
    seen_inst = inst_valid;
    for (int k = 0; k < 2; k++) begin
      tick();
      seen_inst |= inst_valid;
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h20 || ic_addr !== 32'h20) begin
        miscompares++;
        $display("FAIL fmiss_abort_%0d: got req=%b addr=%h ic_addr=%h want req=1 addr=20 ic_addr=20",
                 k, mem_req, mem_addr, ic_addr);
      end
    end
    mem_done = 1'b1; mem_data = 32'hCAFE_0020;
    tick();
    mem_done = 1'b0;
    seen_inst |= inst_valid;
    tick();
    seen_inst |= inst_valid;
    vectors++;
    if (!c_val[8] || c_tag[8] !== 32'h20 || c_data[8] !== 32'hCAFE_0020 || seen_inst) begin
      miscompares++;
      $display("FAIL fmiss_refill: got tag=%h data=%h inst_seen=%b want tag=20 data=cafe0020 inst_seen=0",
               c_tag[8], c_data[8], seen_inst);
    end
    vectors++;
    if (ic_addr !== 32'h100 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL fmiss_next_lookup: got ic_addr=%h req=%b want ic_addr=100 req=0", ic_addr, mem_req);
    end
    tick();
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin
      miscompares++;
      $display("FAIL fmiss_issue: got v=%b pc=%h want v=1 pc=100", inst_valid, inst_pc);
    end
  endtask

  task automatic test_flush_hit();
    cache_clear();
    cache_put(32'h10, word_of(32'h10));
    cache_put(32'h14, word_of(32'h14));
    do_reset();
    flush = 1'b1; flush_pc = 32'h10;
    tick();
    flush = 1'b1; flush_pc = 32'h200;
    tick();
    flush = 1'b0;
    vectors++;
    if (inst_valid !== 1'b0 || ic_addr !== 32'h200 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL fhit_suppress: got v=%b ic_addr=%h req=%b want v=0 ic_addr=200 req=0",
               inst_valid, ic_addr, mem_req);
    end
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fhit_target_miss: got req=%b addr=%h v=%b want req=1 addr=200 v=0",
               mem_req, mem_addr, inst_valid);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pcs[3];
    pcs[0] = 32'hFFFF_FFF8; pcs[1] = 32'hFFFF_FFFC; pcs[2] = 32'h0;
    cache_clear();
    for (int i = 0; i < 3; i++) cache_put(pcs[i], word_of(pcs[i]));
    do_reset();
    flush = 1'b1; flush_pc = 32'hFFFF_FFF8;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (inst_valid !== 1'b1 || inst_pc !== pcs[i] || inst !== word_of(pcs[i])) begin
        miscompares++;
        $display("FAIL wrap_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 i, inst_valid, inst_pc, inst, pcs[i], word_of(pcs[i]));
      end
    end
    vectors++;
    if (ic_addr !== 32'h4) begin
      miscompares++;
      $display("FAIL wrap_next: got ic_addr=%h want 00000004", ic_addr);
    end
  endtask

  task automatic test_rdy_freeze();
    cache_clear();
    do_reset();
    tick();
    rdy_in = 1'b0; flush = 1'b1; flush_pc = 32'h300;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0 || ic_wr !== 1'b0 || ic_value !== 32'h0 ||
          inst_valid !== 1'b0 || ic_addr !== 32'h0 || inst_pc !== 32'h0) begin
        miscompares++;
        $display("FAIL freeze_%0d: got req=%b addr=%h wr=%b val=%h v=%b ic_addr=%h want req=1 addr=0 wr=0 val=0 v=0 ic_addr=0",
                 k, mem_req, mem_addr, ic_wr, ic_value, inst_valid, ic_addr);
      end
    end
    rdy_in = 1'b1; flush = 1'b0;
    mem_done = 1'b1; mem_data = 32'h1234_5678;
    tick();
    mem_done = 1'b0;
    tick();
    vectors++;
    if (ic_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL freeze_flush_ignored: got ic_addr=%h want 00000000", ic_addr);
    end
    tick();
    vectors++;
    if (inst_valid !== 1'b1 || inst !== 32'h1234_5678 || inst_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL freeze_resume: got v=%b inst=%h pc=%h want v=1 inst=12345678 pc=0",
               inst_valid, inst, inst_pc);
    end
    tick();
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    vectors++;
    if (mem_req !== 1'b0 || ic_addr !== RESET_PC || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL miss_reset: got req=%b ic_addr=%h v=%b want req=0 ic_addr=%h v=0",
               mem_req, ic_addr, inst_valid, RESET_PC);
    end
    tick();
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== RESET_PC) begin
      miscompares++;
      $display("FAIL miss_reset_refetch: got v=%b pc=%h want v=1 pc=%h", inst_valid, inst_pc, RESET_PC);
    end
  endtask

  // Model: issued PCs follow pc, pc+4, ... restarting at each accepted
  // redirect; every issued word equals the memory image at its PC.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] fl_pc;
    logic [31:0] ppc;
    logic        pv;
    bit          edge_act;
    bit          fl_s;
    int          emitted;
    int          idle;
    cache_clear();
    for (int a = 0; a < 256; a++) begin
      if ($urandom_range(0, 1) == 1) cache_put(32'(a * 4), word_of(32'(a * 4)));
    end
    do_reset();
    mem_auto = 1'b1;
    exp_pc   = RESET_PC;
    emitted  = 0;
    idle     = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy_in   = ($urandom_range(0, 9) != 0);
      iq_full  = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 39) == 0);
      flush_pc = $urandom_range(0, 255) << 2;
      edge_act = rdy_in;
      fl_s     = flush && rdy_in;
      fl_pc    = flush_pc;
      pv       = inst_valid;
      ppc      = inst_pc;
      tick();
      idle++;
      if (!edge_act) begin
        vectors++;
        if (inst_valid !== pv || inst_pc !== ppc) begin
          miscompares++;
          $display("FAIL rnd_freeze@%0d: got v=%b pc=%h want v=%b pc=%h", cyc, inst_valid, inst_pc, pv, ppc);
        end
      end else if (fl_s) begin
        vectors++;
        if (inst_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL rnd_flush_suppress@%0d: got v=%b want v=0", cyc, inst_valid);
        end
        exp_pc = fl_pc;
        idle   = 0;
      end else if (inst_valid === 1'b1) begin
        vectors++;
        if (inst_pc !== exp_pc || inst !== word_of(exp_pc)) begin
          miscompares++;
          $display("FAIL rnd_issue@%0d: got pc=%h inst=%h want pc=%h inst=%h",
                   cyc, inst_pc, inst, exp_pc, word_of(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        emitted++;
        idle = 0;
      end
      if (mem_req === 1'b1 && mem_busy) begin
        vectors++;
        if (mem_addr !== mem_req_addr) begin
          miscompares++;
          $display("FAIL rnd_mem_addr@%0d: got %h want %h", cyc, mem_addr, mem_req_addr);
        end
      end
      if (idle > 300) begin
        vectors++;
        miscompares++;
        $display("FAIL rnd_timeout@%0d: got no issue for %0d cycles want progress", cyc, idle);
        break;
      end
    end
    vectors++;
    if (emitted < 200) begin
      miscompares++;
      $display("FAIL rnd_throughput: got %0d issued want at least 200", emitted);
    end
    mem_auto = 1'b0; mem_done = 1'b0; rdy_in = 1'b1; flush = 1'b0; iq_full = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; flush_pc = 32'h0;
    iq_full = 1'b0; mem_done = 1'b0; mem_data = 32'h0;
    test_reset();
    test_hits();
    test_cold_miss();
    test_iq_full();
    test_flush_miss();
    test_flush_hit();
    test_wrap();
    test_rdy_freeze();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
